// File: rtl/addsub16_arb_if.sv
// Request/grant and counter-control bundle for addsub16_arb.
// master: requesters plus counter; slave: the arbiter.
interface addsub16_arb_if;
   logic        REQ0;
   logic        REQ1;
   logic        DIR0;
   logic        DIR1;
   logic [7:0]  STEPS0;
   logic [7:0]  STEPS1;
   logic        ACK0;
   logic        ACK1;
   logic        DONE0;
   logic        DONE1;
   logic [7:0]  DONE_STEPS;
   logic        SAT;
   logic        BUSY;
   logic        CNT_EN;
   logic        CNT_SET;
   logic [15:0] CNT_Q;

   modport master (
      output REQ0, REQ1, DIR0, DIR1,
      output STEPS0, STEPS1, CNT_Q,
      input  ACK0, ACK1, DONE0, DONE1,
      input  DONE_STEPS, SAT, BUSY,
      input  CNT_EN, CNT_SET
   );

   modport slave (
      input  REQ0, REQ1, DIR0, DIR1,
      input  STEPS0, STEPS1, CNT_Q,
      output ACK0, ACK1, DONE0, DONE1,
      output DONE_STEPS, SAT, BUSY,
      output CNT_EN, CNT_SET
   );
endinterface

// File: rtl/addsub16_arb.sv
// Round-robin two-requester burst controller for a 16-bit up/down counter.
// Ports: CLK, RST (async active-low), bus (slave side of addsub16_arb_if).
module addsub16_arb (
   input  logic          CLK,
   input  logic          RST,
   addsub16_arb_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_dir;
   logic        r_owner;
   logic        r_last;
   logic        r_ack0;
   logic        r_ack1;
   logic        r_sat;
   logic [7:0]  r_rem;
   logic [7:0]  r_cnt;
   logic [7:0]  r_done_steps;

   logic        w_req_any;
   logic        w_win;
   logic        w_lim;
   logic        w_rem_z;
   logic        w_step;

   assign w_req_any = bus.REQ0 | bus.REQ1;
   // On a tie the requester not granted last wins
   assign w_win     = (bus.REQ0 & bus.REQ1) ? ~r_last : bus.REQ1;

   // Limit in the current direction, checked on the post-step value
   assign w_lim     = r_dir ? (bus.CNT_Q == 16'hFFFF)
                            : (bus.CNT_Q == 16'h0000);
   assign w_rem_z   = (r_rem == 8'd0);
   assign w_step    = (r_state == S_RUN) & ~w_rem_z & ~w_lim;

   assign bus.ACK0       = r_ack0;
   assign bus.ACK1       = r_ack1;
   assign bus.DONE_STEPS = r_done_steps;
   assign bus.SAT        = r_sat;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_req_any) w_next = S_RUN;
         S_RUN:   if (!w_step)   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.CNT_EN  = 1'b0;
      bus.CNT_SET = 1'b0;
      bus.BUSY    = 1'b0;
      bus.DONE0   = 1'b0;
      bus.DONE1   = 1'b0;
      unique case (r_state)
         S_RUN: begin
            bus.CNT_EN  = w_step;
            bus.CNT_SET = r_dir;
            bus.BUSY    = 1'b1;
         end
         S_DONE: begin
            bus.BUSY    = 1'b1;
            bus.DONE0   = ~r_owner;
            bus.DONE1   = r_owner;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_dir        <= 1'b0;
         r_owner      <= 1'b0;
         r_last       <= 1'b1;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_sat        <= 1'b0;
         r_rem        <= 8'd0;
         r_cnt        <= 8'd0;
         r_done_steps <= 8'd0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_req_any) begin
                  r_owner <= w_win;
                  r_last  <= w_win;
                  r_dir   <= w_win ? bus.DIR1 : bus.DIR0;
                  r_rem   <= w_win ? bus.STEPS1 : bus.STEPS0;
                  r_cnt   <= 8'd0;
                  r_ack0  <= ~w_win;
                  r_ack1  <= w_win;
               end
            end
            S_RUN: begin
               if (w_step) begin
                  r_rem <= r_rem - 8'd1;
                  r_cnt <= r_cnt + 8'd1;
               end else begin
                  // Ending with steps left means a limit stopped us
                  r_done_steps <= r_cnt;
                  r_sat        <= ~w_rem_z;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub16_arb.sv
// Testbench for addsub16_arb with a behavioural counter and burst model.
// Ports: none; drives the arbiter through addsub16_arb_if.
module tb_addsub16_arb;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        ld = 1'b0;
   logic [15:0] ld_val = 16'd0;
   logic [15:0] q;
   int          vec = 0;
   int          bad = 0;

   always #5 CLK = ~CLK;

   addsub16_arb_if bus ();

   addsub16_arb dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always_ff @(posedge CLK) begin
      if (ld)              q <= ld_val;
      else if (bus.CNT_EN) q <= bus.CNT_SET ? q + 16'd1 : q - 16'd1;
   end

   assign bus.CNT_Q = q;

   function automatic int model_n(input logic [15:0] st,
                                  input bit d, input int steps);
      int room;
      room = d ? (32'hFFFF - int'(st)) : int'(st);
      return (steps < room) ? steps : room;
   endfunction

   task automatic load_q(input logic [15:0] v);
      @(negedge CLK);
      ld = 1'b1;
      ld_val = v;
      @(negedge CLK);
      ld = 1'b0;
   endtask

   task automatic run_burst(input int who, input bit d, input int steps,
                            input logic [15:0] st, input string tag);
      int n, ack_at, done_at, en_n, busy_n;
      bit sat, both, wrong;
      logic [7:0] ds;
      logic s;
      logic [15:0] qe;
      n = model_n(st, d, steps);
      sat = (n < steps);
      qe = d ? st + 16'(n) : st - 16'(n);
      load_q(st);
      if (who == 0) begin
         bus.REQ0 = 1'b1; bus.DIR0 = d; bus.STEPS0 = 8'(steps);
      end else begin
         bus.REQ1 = 1'b1; bus.DIR1 = d; bus.STEPS1 = 8'(steps);
      end
      ack_at = -1; done_at = -1; en_n = 0; busy_n = 0;
      both = 0; wrong = 0; ds = 8'd0; s = 1'b0;
      for (int t = 1; t <= 600 && done_at < 0; t++) begin
         @(negedge CLK);
         if (bus.ACK0 && bus.ACK1) both = 1;
         if (bus.CNT_EN) en_n++;
         if (bus.BUSY) busy_n++;
         if ((who == 0) ? (bus.ACK1 || bus.DONE1)
                        : (bus.ACK0 || bus.DONE0)) wrong = 1;
         if (((who == 0) ? bus.ACK0 : bus.ACK1) && ack_at < 0) begin
            ack_at = t;
            // Drop the request and scramble fields that must be ignored
            bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
            bus.DIR0 = ~d; bus.DIR1 = ~d;
            bus.STEPS0 = 8'($urandom); bus.STEPS1 = 8'($urandom);
         end
         if ((who == 0) ? bus.DONE0 : bus.DONE1) begin
            done_at = t;
            ds = bus.DONE_STEPS;
            s = bus.SAT;
         end
      end
      bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
      vec++;
      if (done_at < 0) begin
         bad++;
         $display("FAIL %s timeout: no DONE within 600 cycles, need DONE", tag);
      end
      vec++;
      if (ack_at !== 1) begin
         bad++;
         $display("FAIL %s ack_cycle: got %0d need 1", tag, ack_at);
      end
      vec++;
      if (done_at !== n + 2) begin
         bad++;
         $display("FAIL %s done_cycle: got %0d need %0d", tag, done_at, n + 2);
      end
      vec++;
      if (en_n !== n) begin
         bad++;
         $display("FAIL %s en_cycles: got %0d need %0d", tag, en_n, n);
      end
      vec++;
      if (busy_n !== n + 2) begin
         bad++;
         $display("FAIL %s busy_cycles: got %0d need %0d", tag, busy_n, n + 2);
      end
      vec++;
      if (ds !== 8'(n)) begin
         bad++;
         $display("FAIL %s done_steps: got %0d need %0d", tag, ds, n);
      end
      vec++;
      if (s !== sat) begin
         bad++;
         $display("FAIL %s sat: got %0b need %0b", tag, s, sat);
      end
      vec++;
      if (q !== qe) begin
         bad++;
         $display("FAIL %s cnt_q: got %h need %h", tag, q, qe);
      end
      vec++;
      if (both || wrong) begin
         bad++;
         $display("FAIL %s owner: both=%0b wrong=%0b need 0/0", tag, both, wrong);
      end
      @(negedge CLK);
      vec++;
      if (bus.BUSY !== 1'b0 || bus.DONE_STEPS !== 8'(n) || bus.SAT !== sat) begin
         bad++;
         $display("FAIL %s after_done: busy=%b ds=%0d sat=%b need 0/%0d/%0b",
                  tag, bus.BUSY, bus.DONE_STEPS, bus.SAT, n, sat);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      vec++;
      if ({bus.ACK0, bus.ACK1, bus.DONE0, bus.DONE1, bus.SAT, bus.BUSY,
           bus.CNT_EN, bus.CNT_SET} !== 8'd0 || bus.DONE_STEPS !== 8'd0) begin
         bad++;
         $display("FAIL %s reset_outputs: ack=%b%b done=%b%b ds=%0d sat=%b busy=%b en=%b set=%b need all 0",
                  tag, bus.ACK0, bus.ACK1, bus.DONE0, bus.DONE1, bus.DONE_STEPS,
                  bus.SAT, bus.BUSY, bus.CNT_EN, bus.CNT_SET);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLK);
      check_idle_outputs("reset");
      RST = 1'b1;
      @(negedge CLK);
      check_idle_outputs("idle_after_reset");
   endtask

   task automatic test_up();
      run_burst(0, 1'b1, 5, 16'h0010, "up5");
   endtask

   task automatic test_sat_up();
      run_burst(1, 1'b1, 10, 16'hFFFD, "sat_up");
   endtask

   task automatic test_sat_down();
      run_burst(0, 1'b0, 8, 16'h0003, "sat_down");
   endtask

   task automatic test_zero();
      run_burst(0, 1'b1, 0, 16'h1234, "zero_steps");
      run_burst(1, 1'b0, 4, 16'h0000, "start_at_limit");
   endtask

   task automatic test_rr();
      int order[$];
      int dones;
      bit both;
      do_reset();
      load_q(16'h8000);
      bus.DIR0 = 1'b1; bus.DIR1 = 1'b1;
      bus.STEPS0 = 8'd2; bus.STEPS1 = 8'd2;
      bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
      dones = 0; both = 0;
      for (int t = 0; t < 200 && dones < 4; t++) begin
         @(negedge CLK);
         if (bus.ACK0 && bus.ACK1) both = 1;
         if (bus.ACK0) begin order.push_back(0); bus.REQ0 = 1'b0; end
         if (bus.ACK1) begin order.push_back(1); bus.REQ1 = 1'b0; end
         if (bus.DONE0 || bus.DONE1) begin
            dones++;
            if (dones <= 2) begin
               if (bus.DONE0) bus.REQ0 = 1'b1;
               else           bus.REQ1 = 1'b1;
            end
         end
      end
      bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
      vec++;
      if (dones !== 4 || order.size() !== 4) begin
         bad++;
         $display("FAIL rr_count: dones=%0d grants=%0d need 4/4", dones, order.size());
      end else begin
         vec++;
         if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
            bad++;
            $display("FAIL rr_order: got %0d%0d%0d%0d need 0101",
                     order[0], order[1], order[2], order[3]);
         end
      end
      vec++;
      if (both) begin
         bad++;
         $display("FAIL rr_both_ack: got 1 need 0");
      end
   endtask

   task automatic test_rst_mid();
      int en_n;
      bit saw_done;
      run_burst(1, 1'b1, 3, 16'h0200, "pre_rst");
      load_q(16'h0100);
      bus.REQ0 = 1'b1; bus.DIR0 = 1'b1; bus.STEPS0 = 8'd20;
      en_n = 0;
      for (int t = 0; t < 50 && en_n < 3; t++) begin
         @(negedge CLK);
         if (bus.ACK0) bus.REQ0 = 1'b0;
         if (bus.CNT_EN) en_n++;
      end
      vec++;
      if (en_n !== 3) begin
         bad++;
         $display("FAIL rst_mid_reach: en cycles %0d need 3", en_n);
      end
      RST = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      vec++;
      if (q !== 16'h0102) begin
         bad++;
         $display("FAIL rst_mid_cnt: got %h need 0102", q);
      end
      bus.REQ0 = 1'b0;
      saw_done = 0;
      repeat (3) begin
         @(negedge CLK);
         if (bus.DONE0 || bus.DONE1 || bus.CNT_EN) saw_done = 1;
      end
      RST = 1'b1;
      repeat (2) begin
         @(negedge CLK);
         if (bus.DONE0 || bus.DONE1 || bus.CNT_EN) saw_done = 1;
      end
      vec++;
      if (saw_done) begin
         bad++;
         $display("FAIL rst_mid_quiet: activity seen 1 need 0");
      end
      run_burst(0, 1'b0, 4, 16'h0100, "post_rst");
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         int who, steps, mode;
         bit d;
         logic [15:0] st;
         who = int'($urandom_range(0, 1));
         d = 1'($urandom_range(0, 1));
         steps = int'($urandom_range(0, 12));
         mode = int'($urandom_range(0, 2));
         if (mode == 0)      st = 16'hFFFF - 16'($urandom_range(0, 10));
         else if (mode == 1) st = 16'($urandom_range(0, 10));
         else                st = 16'($urandom);
         run_burst(who, d, steps, st, $sformatf("rand%0d", i));
      end
      run_burst(1, 1'b0, 255, 16'h4000, "max_steps");
   endtask

   initial begin
      bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
      bus.DIR0 = 1'b0; bus.DIR1 = 1'b0;
      bus.STEPS0 = 8'd0; bus.STEPS1 = 8'd0;
      test_reset();
      test_up();
      test_sat_up();
      test_sat_down();
      test_zero();
      test_rr();
      test_rst_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
